// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_master among N_REQ client FSMs.
// Latches the winning job, fires one start pulse, and routes handshakes to the owner.
module i2c_bus_arbiter #(
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned START_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0][6:0] req_addr,
    input  logic [N_REQ-1:0]      req_rw,
    input  logic [N_REQ-1:0][7:0] req_nbytes,
    input  logic [N_REQ-1:0][7:0] req_wdata,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      tx_data_req,
    output logic [N_REQ-1:0]      rx_data_ready,
    output logic [7:0]            rdata,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      failed,
    output logic                  m_start,
    output logic [6:0]            m_addr,
    output logic                  m_rw,
    output logic [7:0]            m_nbytes,
    output logic [7:0]            m_wdata,
    input  logic [7:0]            m_read_data,
    input  logic                  m_tx_data_req,
    input  logic                  m_rx_data_ready,
    input  logic                  m_idle,
    input  logic                  m_failed
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_BUSY, S_XFER, S_FINISH
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] failed_q, failed_d;
    logic             m_start_q, m_start_d;
    logic [6:0]       m_addr_q, m_addr_d;
    logic             m_rw_q, m_rw_d;
    logic [7:0]       m_nbytes_q, m_nbytes_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fail_seen_q, fail_seen_d;
    logic             fail_sent_q, fail_sent_d;

    logic [IDX_W-1:0] pick_c;
    logic             any_req_c;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (32'(i) == N_REQ - 1) ? '0 : i + IDX_W'(1);
    endfunction

    // First requester at or after rr_ptr, wrapping upward.
    always_comb begin : rr_pick
        int unsigned      idx;
        logic [IDX_W-1:0] cand;
        pick_c    = '0;
        any_req_c = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = 32'(rr_ptr_q) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = IDX_W'(idx);
            if (!any_req_c && req[cand]) begin
                any_req_c = 1'b1;
                pick_c    = cand;
            end
        end
    end

    always_comb begin : fsm_next
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        failed_d    = '0;
        m_start_d   = 1'b0;
        m_addr_d    = m_addr_q;
        m_rw_d      = m_rw_q;
        m_nbytes_d  = m_nbytes_q;
        cnt_d       = cnt_q;
        fail_seen_d = fail_seen_q;
        fail_sent_d = fail_sent_q;
        unique case (state_q)
            S_IDLE: begin
                // A grant left over from the previous job drops one cycle after its pulse.
                if (gnt_q != '0) begin
                    gnt_d = '0;
                end else if (m_idle && any_req_c) begin
                    owner_d     = pick_c;
                    gnt_d       = N_REQ'(1) << pick_c;
                    m_addr_d    = req_addr[pick_c];
                    m_rw_d      = req_rw[pick_c];
                    m_nbytes_d  = req_nbytes[pick_c];
                    fail_seen_d = 1'b0;
                    fail_sent_d = 1'b0;
                    if (req_nbytes[pick_c] == 8'd0) begin
                        failed_d = N_REQ'(1) << pick_c;
                        rr_ptr_d = next_idx(pick_c);
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                m_start_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!m_idle) begin
                    state_d = S_XFER;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    failed_d    = gnt_q;
                    fail_sent_d = 1'b1;
                    state_d     = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_XFER: begin
                if (m_failed) fail_seen_d = 1'b1;
                if (m_idle)   state_d     = S_FINISH;
            end
            S_FINISH: begin
                // A timeout already reported its failure, so only release the grant.
                if (fail_sent_q) begin
                    gnt_d = '0;
                end else if (fail_seen_q) begin
                    failed_d = gnt_q;
                end else begin
                    done_d = gnt_q;
                end
                rr_ptr_d = next_idx(owner_q);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            failed_q    <= '0;
            m_start_q   <= 1'b0;
            m_addr_q    <= '0;
            m_rw_q      <= 1'b0;
            m_nbytes_q  <= '0;
            cnt_q       <= '0;
            fail_seen_q <= 1'b0;
            fail_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            failed_q    <= failed_d;
            m_start_q   <= m_start_d;
            m_addr_q    <= m_addr_d;
            m_rw_q      <= m_rw_d;
            m_nbytes_q  <= m_nbytes_d;
            cnt_q       <= cnt_d;
            fail_seen_q <= fail_seen_d;
            fail_sent_q <= fail_sent_d;
        end
    end

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign failed        = failed_q;
    assign m_start       = m_start_q;
    assign m_addr        = m_addr_q;
    assign m_rw          = m_rw_q;
    assign m_nbytes      = m_nbytes_q;
    assign m_wdata       = (gnt_q != '0) ? req_wdata[owner_q] : 8'h00;
    assign tx_data_req   = gnt_q & {N_REQ{m_tx_data_req}};
    assign rx_data_ready = gnt_q & {N_REQ{m_rx_data_ready}};
    assign rdata         = m_read_data;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: bench drives the master side by hand.
module tb_i2c_bus_arbiter;

    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req;
    logic [1:0][6:0] req_addr;
    logic [1:0]      req_rw;
    logic [1:0][7:0] req_nbytes;
    logic [1:0][7:0] req_wdata;
    logic [1:0]      gnt, tx_data_req, rx_data_ready, done, failed;
    logic [7:0]      rdata;
    logic            m_start, m_rw;
    logic [6:0]      m_addr;
    logic [7:0]      m_nbytes, m_wdata, m_read_data;
    logic            m_tx_data_req, m_rx_data_ready, m_idle, m_failed;

    int checks = 0;
    int errors = 0;
    int n_start = 0, n_done0 = 0, n_done1 = 0, n_fail0 = 0, n_fail1 = 0, n_rx0 = 0, n_rx1 = 0;

    i2c_bus_arbiter #(.N_REQ(2), .START_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_nbytes(req_nbytes), .req_wdata(req_wdata),
        .gnt(gnt), .tx_data_req(tx_data_req), .rx_data_ready(rx_data_ready),
        .rdata(rdata), .done(done), .failed(failed),
        .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_nbytes(m_nbytes),
        .m_wdata(m_wdata), .m_read_data(m_read_data), .m_tx_data_req(m_tx_data_req),
        .m_rx_data_ready(m_rx_data_ready), .m_idle(m_idle), .m_failed(m_failed)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_start === 1'b1)          n_start++;
        if (done[0] === 1'b1)          n_done0++;
        if (done[1] === 1'b1)          n_done1++;
        if (failed[0] === 1'b1)        n_fail0++;
        if (failed[1] === 1'b1)        n_fail1++;
        if (rx_data_ready[0] === 1'b1) n_rx0++;
        if (rx_data_ready[1] === 1'b1) n_rx1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag);
        int t;
        t = 0;
        while (m_start !== 1'b1 && t < 40) begin
            step();
            t++;
        end
        check(tag, 32'(m_start), 32'd1);
    endtask

    // Emulate one master transfer for whichever client was granted.
    task automatic serve(input int busy, input int fail_mode, input bit keep_req,
                         output int owner, output bit got_done, output bit got_failed);
        int t;
        wait_start("serve_start");
        owner  = (gnt === 2'b10) ? 1 : 0;
        m_idle = 1'b0;
        for (int c = 0; c < busy; c++) begin
            m_failed = (fail_mode == 1 && c == busy / 2);
            step();
        end
        m_failed = (fail_mode == 2);
        m_idle   = 1'b1;
        step();
        m_failed = 1'b0;
        t = 0;
        while (done === 2'b00 && failed === 2'b00 && t < 10) begin
            step();
            t++;
        end
        got_done   = |done;
        got_failed = |failed;
        if (!keep_req) req[owner] = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int  own;
        bit  gd, gf;
        int  s0, s1, s2, s3, t;
        bit  any_gnt;
        logic [7:0] rd_bytes [6];
        rd_bytes = '{8'h11, 8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h7E};

        rst_n = 1'b0; req = '0; req_addr = '0; req_rw = '0; req_nbytes = '0; req_wdata = '0;
        m_read_data = '0; m_tx_data_req = 1'b0; m_rx_data_ready = 1'b0;
        m_idle = 1'b1; m_failed = 1'b0;
        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_start", 32'(m_start), 32'h0);
        check("rst_done_failed", 32'({done, failed}), 32'h0);
        check("rst_maddr", 32'(m_addr), 32'h0);
        check("rst_wdata", 32'(m_wdata), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Single write to 0x45, two bytes
        s0 = n_start; s1 = n_done0; s2 = n_fail0 + n_fail1;
        req_addr[0] = 7'h45; req_rw[0] = 1'b0; req_nbytes[0] = 8'd2; req_wdata[0] = 8'h2C;
        req[0] = 1'b1;
        step();
        check("sw_gnt", 32'(gnt), 32'h1);
        check("sw_start_early", 32'(m_start), 32'h0);
        step();
        check("sw_start", 32'(m_start), 32'h1);
        check("sw_addr", 32'(m_addr), 32'h45);
        check("sw_rw", 32'(m_rw), 32'h0);
        check("sw_nbytes", 32'(m_nbytes), 32'h2);
        check("sw_wdata0", 32'(m_wdata), 32'h2C);
        m_idle = 1'b0;
        step();
        check("sw_start_pulse", 32'(m_start), 32'h0);
        step();
        m_tx_data_req = 1'b1;
        #1;
        check("sw_txreq", 32'(tx_data_req), 32'h1);
        step();
        m_tx_data_req = 1'b0;
        req_wdata[0]  = 8'h06;
        #1;
        check("sw_wdata1", 32'(m_wdata), 32'h06);
        step();
        m_idle = 1'b1;
        step();
        check("sw_done_early", 32'(done), 32'h0);
        step();
        check("sw_done", 32'(done), 32'h1);
        check("sw_gnt_hold", 32'(gnt), 32'h1);
        req[0] = 1'b0;
        step();
        check("sw_gnt_clr", 32'(gnt), 32'h0);
        check("sw_done_pulse", 32'(done), 32'h0);
        check("sw_nstart", 32'(n_start - s0), 32'd1);
        check("sw_ndone", 32'(n_done0 - s1), 32'd1);
        check("sw_nfail", 32'(n_fail0 + n_fail1 - s2), 32'd0);

        // Contention from rr_ptr=0; client 0 keeps requesting after its turn
        do_reset();
        req_addr[0] = 7'h10; req_addr[1] = 7'h20; req_rw = 2'b00;
        req_nbytes[0] = 8'd1; req_nbytes[1] = 8'd1;
        req = 2'b11;
        step();
        check("ct_first_gnt", 32'(gnt), 32'h1);
        serve(2, 0, 1'b1, own, gd, gf);
        check("ct_owner0", 32'(own), 32'd0);
        check("ct_done0", 32'(gd), 32'd1);
        step();
        check("ct_b2b_gap", 32'(m_start), 32'h0);
        step();
        check("ct_b2b_start", 32'(m_start), 32'h1);
        check("ct_b2b_gnt", 32'(gnt), 32'h2);
        serve(2, 0, 1'b0, own, gd, gf);
        check("ct_owner1", 32'(own), 32'd1);
        serve(2, 0, 1'b0, own, gd, gf);
        check("ct_owner0_again", 32'(own), 32'd0);

        // Read routing: client 1 reads six bytes
        s0 = n_rx0; s1 = n_rx1; s2 = n_done1;
        req_addr[1] = 7'h50; req_rw[1] = 1'b1; req_nbytes[1] = 8'd6;
        req[1] = 1'b1;
        wait_start("rd_start");
        check("rd_gnt", 32'(gnt), 32'h2);
        check("rd_rw", 32'(m_rw), 32'h1);
        check("rd_addr", 32'(m_addr), 32'h50);
        m_idle = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            m_read_data     = rd_bytes[i];
            m_rx_data_ready = 1'b1;
            #1;
            check("rd_rdata", 32'(rdata), 32'(rd_bytes[i]));
            check("rd_route", 32'(rx_data_ready), 32'h2);
            step();
            m_rx_data_ready = 1'b0;
            step();
        end
        m_read_data = 8'h00;
        m_idle = 1'b1;
        step();
        step();
        check("rd_done", 32'(done), 32'h2);
        req[1] = 1'b0;
        step();
        check("rd_nrx1", 32'(n_rx1 - s1), 32'd6);
        check("rd_nrx0", 32'(n_rx0 - s0), 32'd0);
        check("rd_ndone1", 32'(n_done1 - s2), 32'd1);

        // Master failure mid-transfer with client 1 pending
        s0 = n_fail0; s1 = n_done0;
        req_rw = 2'b00; req_nbytes[0] = 8'd3; req_nbytes[1] = 8'd3;
        req = 2'b11;
        serve(4, 1, 1'b0, own, gd, gf);
        check("mf_owner", 32'(own), 32'd0);
        check("mf_failed", 32'(gf), 32'd1);
        check("mf_nodone", 32'(gd), 32'd0);
        check("mf_nfail0", 32'(n_fail0 - s0), 32'd1);
        check("mf_ndone0", 32'(n_done0 - s1), 32'd0);
        serve(3, 0, 1'b0, own, gd, gf);
        check("mf_next_owner", 32'(own), 32'd1);
        check("mf_next_done", 32'(gd), 32'd1);

        // m_failed and m_idle rise together: one failed, no done
        s0 = n_fail0; s1 = n_done0;
        req[0] = 1'b1;
        serve(3, 2, 1'b0, own, gd, gf);
        step();
        check("sim_nfail0", 32'(n_fail0 - s0), 32'd1);
        check("sim_ndone0", 32'(n_done0 - s1), 32'd0);

        // Start timeout: master never leaves idle
        s1 = n_done0; s3 = n_fail0;
        req_nbytes[0] = 8'd1;
        req[0] = 1'b1;
        wait_start("to_start");
        t = 0;
        while (failed === 2'b00 && t < TO + 10) begin
            step();
            t++;
        end
        check("to_latency", 32'(t), 32'(TO));
        check("to_failed", 32'(failed), 32'h1);
        req[0] = 1'b0;
        step();
        check("to_gnt_clr", 32'(gnt), 32'h0);
        step();
        check("to_nfail", 32'(n_fail0 - s3), 32'd1);
        check("to_ndone", 32'(n_done0 - s1), 32'd0);

        // Zero-length job is rejected without a start
        s0 = n_start;
        req_nbytes[1] = 8'd0;
        req[1] = 1'b1;
        step();
        check("zl_failed", 32'(failed), 32'h2);
        check("zl_gnt", 32'(gnt), 32'h2);
        check("zl_nostart", 32'(m_start), 32'h0);
        req[1] = 1'b0;
        step();
        check("zl_gnt_clr", 32'(gnt), 32'h0);
        check("zl_failed_pulse", 32'(failed), 32'h0);
        repeat (3) step();
        check("zl_nstart", 32'(n_start - s0), 32'd0);

        // Async reset during XFER, then a busy bus after release
        req_nbytes[0] = 8'd4; req_addr[0] = 7'h33;
        req[0] = 1'b1;
        wait_start("ar_start");
        m_idle = 1'b0;
        step();
        step();
        m_tx_data_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_gnt", 32'(gnt), 32'h0);
        check("ar_txreq", 32'(tx_data_req), 32'h0);
        check("ar_maddr", 32'(m_addr), 32'h0);
        check("ar_mnbytes", 32'(m_nbytes), 32'h0);
        check("ar_wdata", 32'(m_wdata), 32'h0);
        check("ar_pulses", 32'({done, failed, m_start}), 32'h0);
        m_tx_data_req = 1'b0;
        step();
        rst_n = 1'b1;
        any_gnt = 1'b0;
        repeat (50) begin
            step();
            if (gnt !== 2'b00) any_gnt = 1'b1;
        end
        check("ar_busy_nogrant", 32'(any_gnt), 32'd0);
        m_idle = 1'b1;
        step();
        check("ar_regrant", 32'(gnt), 32'h1);
        step();
        check("ar_restart", 32'(m_start), 32'h1);
        req[0] = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
